// File: rtl/loom_fp_pkg.sv
// ============================================================================
//  Module      : loom_fp_pkg
//  Description : Shared floating-point format helpers and converter FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package loom_fp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } fp_cvt_state_e;

    function automatic int mant_bits(input int width);
        return (width == 64) ? 52 : 23;
    endfunction

    function automatic int exp_bits(input int width);
        return (width == 64) ? 11 : 8;
    endfunction

    function automatic int exp_bias(input int width);
        return (width == 64) ? 1023 : 127;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_round_rne.sv
// ============================================================================
//  Module      : fp_round_rne
//  Description : Packs a normalized magnitude into IEEE-754 with round-to-nearest-even.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_round_rne
    import loom_fp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-2:0]              i_frac,
    input  logic [exp_bits(WIDTH)-1:0]    i_exp,
    input  logic                          i_sign,
    output logic [WIDTH-1:0]              o_float
);

    localparam int              c_m    = mant_bits(WIDTH);
    localparam int              c_ew   = exp_bits(WIDTH);
    localparam logic [c_ew-1:0] c_bias = c_ew'(exp_bias(WIDTH));

    logic [c_m-1:0]  w_mant;
    logic            w_guard;
    logic            w_sticky;
    logic            w_round_up;
    logic [c_m:0]    w_mant_sum;
    logic [c_ew-1:0] w_exp_out;

    // i_frac excludes the leading one, which is implicit in the encoding
    assign w_mant     = i_frac[WIDTH-2 -: c_m];
    assign w_guard    = i_frac[WIDTH-2-c_m];
    assign w_sticky   = |i_frac[WIDTH-3-c_m:0];
    assign w_round_up = w_guard & (w_sticky | w_mant[0]);

    // A carry out of the mantissa leaves it all zero and bumps the exponent
    assign w_mant_sum = {1'b0, w_mant} + {{c_m{1'b0}}, w_round_up};
    assign w_exp_out  = i_exp + c_bias + {{(c_ew-1){1'b0}}, w_mant_sum[c_m]};

    assign o_float = {i_sign, w_exp_out, w_mant_sum[c_m-1:0]};

endmodule

`default_nettype wire

// File: rtl/arith_sitofp_seq.sv
// ============================================================================
//  Module      : arith_sitofp_seq
//  Description : Iterative integer to IEEE-754 converter with valid/ready handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arith_sitofp_seq
    import loom_fp_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    generate
        if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
            $fatal(1, "arith_sitofp_seq: WIDTH must be 32 or 64");
        end
    endgenerate

    localparam int         c_ew       = exp_bits(WIDTH);
    localparam logic [1:0] c_st_idle  = IDLE;
    localparam logic [1:0] c_st_norm  = NORM;
    localparam logic [1:0] c_st_round = ROUND;
    localparam logic [1:0] c_st_done  = DONE;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_mag;
    logic [c_ew-1:0]  r_exp;
    logic             r_sign;
    logic [WIDTH-1:0] r_out_data;

    logic             w_in_neg;
    logic [WIDTH-1:0] w_in_mag;
    logic [WIDTH-1:0] w_rounded;

    // The most negative input negates to itself, which is 2^(WIDTH-1) unsigned
    assign w_in_neg = SIGNED & in_data[WIDTH-1];
    assign w_in_mag = w_in_neg ? -in_data : in_data;

    fp_round_rne #(
        .WIDTH (WIDTH)
    ) u_round (
        .i_frac  (r_mag[WIDTH-2:0]),
        .i_exp   (r_exp),
        .i_sign  (r_sign),
        .o_float (w_rounded)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_mag      <= '0;
            r_exp      <= '0;
            r_sign     <= 1'b0;
            r_out_data <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_sign  <= w_in_neg;
                        r_mag   <= w_in_mag;
                        r_exp   <= c_ew'(WIDTH - 1);
                        r_state <= c_st_norm;
                    end
                end
                c_st_norm: begin
                    if (r_mag == '0) begin
                        r_out_data <= '0;
                        r_state    <= c_st_done;
                    end else if (r_mag[WIDTH-1]) begin
                        r_state <= c_st_round;
                    end else begin
                        r_mag <= {r_mag[WIDTH-2:0], 1'b0};
                        r_exp <= r_exp - 1'b1;
                    end
                end
                c_st_round: begin
                    r_out_data <= w_rounded;
                    r_state    <= c_st_done;
                end
                c_st_done: begin
                    if (out_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign in_ready  = (r_state == c_st_idle);
    assign out_valid = (r_state == c_st_done);
    assign out_data  = r_out_data;

endmodule

`default_nettype wire
